// File: rtl/div_unit_pkg.sv
// Shared definitions for the radix-2 divider: FSM state encoding and handshake levels.
package div_unit_pkg;

  localparam int DIV_DATA_W = 32;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_t;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_unit_if.sv
// EX-stage divide handshake: EX is the master, the divider is the slave.
interface div_unit_if #(parameter int DATA_W = 32);

  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift the remainder/quotient word left, try to
// subtract the divisor from the upper half, and record the outcome as the new quotient bit.
module div_unit_step #(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W:0]   acc,
  input  logic [DATA_W-1:0]   divisor,
  output logic [2*DATA_W:0]   acc_next
);

  logic [DATA_W+1:0] partial;
  logic [DATA_W+1:0] diff;

  // The partial remainder keeps an extra top bit so divisors above 2^(DATA_W-1) work.
  always_comb begin
    partial  = acc[2*DATA_W:DATA_W-1];
    diff     = partial - {2'b00, divisor};
    acc_next = {acc[2*DATA_W-1:0], 1'b0};
    if (!diff[DATA_W+1]) begin
      acc_next = {diff[DATA_W:0], acc[DATA_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider answering the EX-stage start/ready handshake.
// Result is {remainder, quotient}; operands are sampled only when a division starts.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int ITER   = DATA_W
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(ITER + 1);

  div_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [2*DATA_W:0]     acc_q, acc_next;
  logic [DATA_W-1:0]     divisor_q;
  logic                  signed_q, sign1_q, sign2_q;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;
  logic                  sign1_in, sign2_in, stop_req;
  logic [DATA_W-1:0]     quot_fix, rem_fix;

  function automatic logic [DATA_W-1:0] cond_neg(input logic neg, input logic [DATA_W-1:0] v);
    return neg ? ({DATA_W{1'b0}} - v) : v;
  endfunction

  div_unit_step #(.DATA_W(DATA_W)) u_step (
    .acc      (acc_q),
    .divisor  (divisor_q),
    .acc_next (acc_next)
  );

  assign sign1_in = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
  assign sign2_in = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
  assign stop_req = bus.annul_i | (bus.start_i == DIV_STOP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= DIV_FREE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_FREE: begin
        if (bus.start_i == DIV_START && !bus.annul_i) begin
          state_d = (bus.opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
        end
      end
      DIV_BYZERO: state_d = stop_req ? DIV_FREE : DIV_END;
      DIV_ON: begin
        if (stop_req)                           state_d = DIV_FREE;
        else if (cnt_q == CNT_W'(ITER - 1))     state_d = DIV_END;
      end
      DIV_END: if (stop_req) state_d = DIV_FREE;
      default: state_d = DIV_FREE;
    endcase
  end

  // Sign correction applies on the final step, using the signs latched at start.
  always_comb begin
    quot_fix = cond_neg(sign1_q ^ sign2_q, acc_next[DATA_W-1:0]);
    rem_fix  = cond_neg(sign1_q, acc_next[2*DATA_W-1:DATA_W]);
    ready_d  = DIV_RESULT_NOT_READY;
    result_d = '0;
    if (state_d == DIV_END) begin
      ready_d = DIV_RESULT_READY;
      case (state_q)
        DIV_ON:  result_d = {rem_fix, quot_fix};
        DIV_END: result_d = result_q;
        default: result_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      divisor_q <= '0;
      signed_q  <= 1'b0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      result_q  <= '0;
      ready_q   <= DIV_RESULT_NOT_READY;
    end else begin
      if (state_q == DIV_FREE && state_d == DIV_ON) begin
        cnt_q     <= '0;
        acc_q     <= {{(DATA_W+1){1'b0}}, cond_neg(sign1_in, bus.opdata1_i)};
        divisor_q <= cond_neg(sign2_in, bus.opdata2_i);
        signed_q  <= bus.signed_div_i;
        sign1_q   <= sign1_in;
        sign2_q   <= sign2_in;
      end else if (state_q == DIV_ON) begin
        acc_q <= acc_next;
        cnt_q <= cnt_q + 1'b1;
      end
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule
